ctx_stack_seq: RTL
==================

Name: ctx_stack_seq

Overview:
- Push/pop initiator for the 32-bit hardware stack. On a save request it spills a contiguous block of register-file entries onto the stack. On a restore request it pops them back in reverse order.
- Sits between the CPU control unit (interrupt entry/exit, multi-register PUSH/POP) and the stack and register file.
- Drives the stack's push/pop/wdata interface and consumes its rdata/full/empty status.

Parameters:
- NREGS, 16, number of registers per frame (r0..rNREGS-1), 1..2^AW
- AW, 4, register-file address width
- DW, 32, data width (matches stack word)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- save_req  in  1  start frame save; sampled only in IDLE
- restore_req  in  1  start frame restore; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of operation (success or abort)
- err  out  1  sticky abort flag; cleared when the next request is accepted
- rf_raddr  out  AW  register-file read address (combinational read)
- rf_rdata  in  DW  register-file read data
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- stk_push  out  1  push strobe to stack
- stk_pop  out  1  pop strobe to stack
- stk_wdata  out  DW  data to push
- stk_rdata  in  DW  current top-of-stack word
- stk_full  in  1  stack full
- stk_empty  in  1  stack empty

Behaviour:
- Reset:
  - state=IDLE, index counter=0, err=0.
  - busy, done, rf_we, stk_push and stk_pop are 0.
  - rf_raddr, rf_waddr, rf_wdata and stk_wdata are 0.
- States: IDLE, SAVE, RESTORE, DONE (plus TAG_PUSH and TAG_CHK when the optional feature is enabled).
- IDLE:
  - save_req=1 -> SAVE, idx=0, err cleared.
  - Otherwise restore_req=1 -> RESTORE, idx=0, err cleared.
  - Simultaneous save_req and restore_req: save wins.
- SAVE, per cycle:
  - rf_raddr=idx, stk_wdata=rf_rdata, stk_push=1 combinationally.
  - If stk_full=1 in any SAVE cycle: stk_push=0, err<=1, go to DONE. The partial frame stays on the stack.
  - After idx=NREGS-1 is pushed: go to DONE.
  - A full save takes exactly NREGS push cycles.
- RESTORE, per cycle:
  - stk_pop=1, rf_we=1, rf_waddr=NREGS-1-idx, rf_wdata=stk_rdata.
  - The stack updates between edges, so stk_rdata presents the next word at the following posedge.
  - If stk_empty=1: stk_pop=0, rf_we=0, err<=1, go to DONE. Already-restored registers keep their new values; the rest are untouched.
  - After idx=NREGS-1: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is high from the cycle after acceptance through the DONE cycle.
- Strobe rules: stk_push and stk_pop are never high in the same cycle. rf_we is high only in RESTORE/TAG_CHK-success paths.
- Ignored requests: requests while busy are ignored, not queued.
- Latency: the first strobe appears in the cycle after the request is sampled. Total busy = NREGS+1 cycles (no abort, feature off).
- idx width is AW+1 so that NREGS=2^AW does not wrap.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. Stack contents are not repaired.

Optional Feature:
- Macro: CTX_STACK_TAG_EN.
- Defined, save side: after the last register, TAG_PUSH pushes one tag word {16'hC0DE, 16'(NREGS)}. The full check applies to the tag as well; total save = NREGS+1 pushes.
- Defined, restore side:
  - RESTORE is preceded by TAG_CHK, which pops one word and compares it to the tag.
  - Mismatch or empty -> err<=1, go to DONE, no rf_we asserted.
  - Match -> RESTORE as normal.
- Undefined: TAG_PUSH and TAG_CHK states are absent; the frame is exactly NREGS words.

Test Plan:
- Save, NREGS=16, rf[i]=32'h1000_0000+i, empty stack -> 16 consecutive stk_push cycles with wdata 0x10000000..0x1000000F; done pulse at cycle 17; err=0.
- Save, then zero the register file, then restore -> rf_waddr sequence 15..0, rf[i] back to 0x10000000+i; stk_empty=1 at end; err=0.
- Restore with only 5 words on the stack -> r15..r11 written, stk_empty seen on the 6th cycle, no further writes, err=1, done pulse.
- save_req and restore_req both high in IDLE -> save executes; restore_req pulsed mid-save is ignored (no stk_pop ever asserted).
- Assert rst during the 7th SAVE cycle -> busy=0 and stk_push=0 immediately; the next save_req starts again at idx=0.
- CTX_STACK_TAG_EN defined:
  - Save pushes 17 words, the last being 32'hC0DE_0010.
  - Corrupting that word before restore -> err=1, zero rf_we pulses.

Source files
------------

// File: rtl/ctx_stack_seq.sv
// ctx_stack_seq: spills a register-file frame onto the hardware stack and pops it back in reverse.
// Define CTX_STACK_TAG_EN to push a tag word after each save and verify it before each restore.
module ctx_stack_seq #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          save_req,
    input  logic          restore_req,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [DW-1:0] stk_wdata,
    input  logic [DW-1:0] stk_rdata,
    input  logic          stk_full,
    input  logic          stk_empty
);
    localparam int IW = AW + 1;
    localparam logic [IW-1:0] LAST = IW'(NREGS - 1);
`ifdef CTX_STACK_TAG_EN
    localparam logic [DW-1:0] TAG = DW'({16'hC0DE, 16'(NREGS)});
    typedef enum logic [2:0] {IDLE, SAVE, RESTORE, DONE, TAG_PUSH, TAG_CHK} state_t;
    localparam state_t SAVE_END   = TAG_PUSH;
    localparam state_t LOAD_BEGIN = TAG_CHK;
`else
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;
    localparam state_t SAVE_END   = DONE;
    localparam state_t LOAD_BEGIN = RESTORE;
`endif

    state_t        state;
    logic [IW-1:0] idx;
    logic          last;

    assign last = idx == LAST;
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (save_req || restore_req) begin
                    state <= save_req ? SAVE : LOAD_BEGIN;
                    idx   <= '0;
                    err   <= 1'b0;
                end
                SAVE: if (stk_full) begin
                    err   <= 1'b1;
                    state <= DONE;
                end else if (last) state <= SAVE_END;
                else idx <= idx + 1'b1;
                RESTORE: if (stk_empty) begin
                    err   <= 1'b1;
                    state <= DONE;
                end else if (last) state <= DONE;
                else idx <= idx + 1'b1;
`ifdef CTX_STACK_TAG_EN
                TAG_PUSH: begin
                    if (stk_full) err <= 1'b1;
                    state <= DONE;
                end
                TAG_CHK: if (stk_empty || stk_rdata != TAG) begin
                    err   <= 1'b1;
                    state <= DONE;
                end else state <= RESTORE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are combinational so a full/empty stack suppresses them in the same cycle.
    always_comb begin
        rf_raddr  = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_wdata = '0;
        case (state)
            SAVE: begin
                rf_raddr  = idx[AW-1:0];
                stk_wdata = rf_rdata;
                stk_push  = !stk_full;
            end
            RESTORE: begin
                stk_pop  = !stk_empty;
                rf_we    = !stk_empty;
                rf_waddr = AW'(NREGS - 1) - idx[AW-1:0];
                rf_wdata = stk_rdata;
            end
`ifdef CTX_STACK_TAG_EN
            TAG_PUSH: begin
                stk_wdata = TAG;
                stk_push  = !stk_full;
            end
            TAG_CHK: stk_pop = !stk_empty;
`endif
            default: ;
        endcase
    end
endmodule
